// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU-side constants and the sprite DMA state type
package ppu_pkg;

    localparam logic [2:0]  OAMDATA_ADDR = 3'd4;
    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
    localparam logic [2:0]  OAMDATA_REG  = OAMDATA_ADDR;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA: copies one 256-byte CPU page into PPU OAMDATA while the CPU is halted
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [2:0]  OAMDATA_REG  = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_rw_i,
    input  logic [7:0]  bus_data_i,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic [15:0] bus_addr_o,
    output logic        bus_rw_o,
    output logic        ppu_cs,
    output logic [2:0]  ppu_addr,
    output logic        ppu_rw,
    output logic [7:0]  ppu_data
);
    import ppu_pkg::*;

    dma_state_t  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic        parity_q, parity_d;
    logic [7:0]  ppu_data_q, ppu_data_d;
    logic        cpu_halt_q, cpu_halt_d;
    logic        ppu_cs_q, ppu_cs_d;
    logic        ppu_rw_q, ppu_rw_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic        trigger;

    assign trigger = !cpu_rw_i && (cpu_addr_i == DMA_REG_ADDR);

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        parity_d   = parity_q;
        ppu_data_d = ppu_data_q;
        if (cpu_ce) begin
            parity_d = ~parity_q;
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        page_d  = cpu_data_i;
                        idx_d   = 8'd0;
                        state_d = HALT;
                    end
                end
                // An odd halt cycle needs one extra cycle so reads land on even cycles.
                HALT:    state_d = parity_q ? ALIGN : READ;
                ALIGN:   state_d = READ;
                READ: begin
                    ppu_data_d = bus_data_i;
                    state_d    = WRITE;
                end
                WRITE: begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == 8'hFF) ? IDLE : READ;
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered from the next state so they move together with it.
        cpu_halt_d = (state_d != IDLE);
        ppu_cs_d   = (state_d == WRITE);
        ppu_rw_d   = !ppu_cs_d;
        bus_addr_d = (state_d != IDLE) ? {page_d, idx_d} : bus_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            page_q     <= 8'd0;
            idx_q      <= 8'd0;
            parity_q   <= 1'b0;
            ppu_data_q <= 8'd0;
            cpu_halt_q <= 1'b0;
            ppu_cs_q   <= 1'b0;
            ppu_rw_q   <= 1'b1;
            bus_addr_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            idx_q      <= idx_d;
            parity_q   <= parity_d;
            ppu_data_q <= ppu_data_d;
            cpu_halt_q <= cpu_halt_d;
            ppu_cs_q   <= ppu_cs_d;
            ppu_rw_q   <= ppu_rw_d;
            bus_addr_q <= bus_addr_d;
        end
    end

    assign cpu_halt   = cpu_halt_q;
    assign dma_active = cpu_halt_q;
    assign bus_addr_o = bus_addr_q;
    assign bus_rw_o   = 1'b1;
    assign ppu_cs     = ppu_cs_q;
    assign ppu_addr   = OAMDATA_REG;
    assign ppu_rw     = ppu_rw_q;
    assign ppu_data   = ppu_data_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - table-driven bench for oam_dma with a page-pattern memory model
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce;
    logic [15:0] cpu_addr_i;
    logic [7:0]  cpu_data_i;
    logic        cpu_rw_i;
    logic [7:0]  bus_data_i;
    logic        cpu_halt;
    logic        dma_active;
    logic [15:0] bus_addr_o;
    logic        bus_rw_o;
    logic        ppu_cs;
    logic [2:0]  ppu_addr;
    logic        ppu_rw;
    logic [7:0]  ppu_data;

    oam_dma dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce     (cpu_ce),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_rw_i   (cpu_rw_i),
        .bus_data_i (bus_data_i),
        .cpu_halt   (cpu_halt),
        .dma_active (dma_active),
        .bus_addr_o (bus_addr_o),
        .bus_rw_o   (bus_rw_o),
        .ppu_cs     (ppu_cs),
        .ppu_addr   (ppu_addr),
        .ppu_rw     (ppu_rw),
        .ppu_data   (ppu_data)
    );

    always #5 clk = ~clk;

    // Memory: byte at {page, i} is i ^ page ^ 8'hA7, so page 8'h02 holds i ^ 8'hA5.
    assign bus_data_i = bus_addr_o[7:0] ^ bus_addr_o[15:8] ^ 8'hA7;

    typedef struct {
        logic [7:0]  page;
        bit          even_halt;
        int          retrig_at;
        int          rst_at;
        int          ce_div;
        int          exp_halt;
        int          exp_writes;
        logic [15:0] exp_last;
    } row_t;

    row_t rows [7];

    int checks = 0;
    int failures = 0;
    int ce_count = 0;
    int ce_period = 1;
    int cyc = 0;
    int writes, data_errs, addr_errs, gap_errs, hold_errs, cs_errs, last_write_cyc, halt_len;
    logic [7:0]  cur_page;
    logic [15:0] last_addr;
    logic        prev_cs = 1'b0;
    logic        zero_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sample();
        logic [7:0] n;
        if (ppu_cs && !prev_cs) begin
            n = writes[7:0];
            if (ppu_data !== (n ^ cur_page ^ 8'hA7)) data_errs++;
            if (bus_addr_o !== {cur_page, n}) addr_errs++;
            if (ppu_addr !== 3'd4 || ppu_rw !== 1'b0) cs_errs++;
            if (writes > 0 && cyc != last_write_cyc + 2) gap_errs++;
            last_write_cyc = cyc;
            last_addr = bus_addr_o;
            writes++;
        end
        if (ppu_cs && !dma_active) cs_errs++;
        if (!ppu_cs && ppu_rw !== 1'b1) cs_errs++;
        if (bus_rw_o !== 1'b1) cs_errs++;
        if (dma_active && bus_addr_o == 16'h0000) zero_addr = 1'b1;
        prev_cs = ppu_cs;
    endtask

    task automatic tick(input logic ce);
        cpu_ce = ce;
        @(posedge clk);
        #1;
        if (ce && !rst) ce_count++;
        sample();
    endtask

    task automatic cpu_cycle();
        logic [28:0] snap;
        snap = {cpu_halt, dma_active, bus_addr_o, ppu_cs, ppu_rw, ppu_data};
        for (int k = 0; k < ce_period - 1; k++) begin
            tick(1'b0);
            if ({cpu_halt, dma_active, bus_addr_o, ppu_cs, ppu_rw, ppu_data} !== snap) hold_errs++;
        end
        cyc++;
        tick(1'b1);
    endtask

    task automatic do_transfer(input row_t r, input int row_no);
        bit did_reset;
        ce_period = r.ce_div;
        cur_page = r.page;
        writes = 0; data_errs = 0; addr_errs = 0; gap_errs = 0; hold_errs = 0; cs_errs = 0;
        last_write_cyc = 0; last_addr = 16'h0; zero_addr = 1'b0; halt_len = 0; did_reset = 0;

        if ((((ce_count + 1) % 2) == 0) != r.even_halt) cpu_cycle();
        cpu_addr_i = 16'h4014; cpu_rw_i = 1'b0; cpu_data_i = r.page;
        cpu_cycle();
        cpu_addr_i = 16'h0000; cpu_rw_i = 1'b1; cpu_data_i = 8'h00;
        chk($sformatf("row%0d_halt_rise", row_no), cpu_halt, 1'b1);

        for (int k = 0; k < 700 && cpu_halt; k++) begin
            if (r.rst_at >= 0 && writes == r.rst_at) begin
                rst = 1'b1;
                tick(1'b0);
                chk($sformatf("row%0d_rst_halt", row_no), cpu_halt, 1'b0);
                chk($sformatf("row%0d_rst_cs", row_no), ppu_cs, 1'b0);
                chk($sformatf("row%0d_rst_active", row_no), dma_active, 1'b0);
                chk($sformatf("row%0d_rst_addr", row_no), bus_addr_o, 16'h0000);
                rst = 1'b0;
                ce_count = 0;
                did_reset = 1;
                break;
            end
            halt_len++;
            if (r.retrig_at >= 0 && writes == r.retrig_at) begin
                cpu_addr_i = 16'h4014; cpu_rw_i = 1'b0; cpu_data_i = 8'h07;
                cpu_cycle();
                cpu_addr_i = 16'h0000; cpu_rw_i = 1'b1; cpu_data_i = 8'h00;
            end else begin
                cpu_cycle();
            end
        end

        chk($sformatf("row%0d_done", row_no), cpu_halt, 1'b0);
        if (!did_reset) chk($sformatf("row%0d_halt_len", row_no), halt_len, r.exp_halt);
        chk($sformatf("row%0d_writes", row_no), writes, r.exp_writes);
        chk($sformatf("row%0d_data_errs", row_no), data_errs, 0);
        chk($sformatf("row%0d_addr_errs", row_no), addr_errs, 0);
        chk($sformatf("row%0d_gap_errs", row_no), gap_errs, 0);
        chk($sformatf("row%0d_hold_errs", row_no), hold_errs, 0);
        chk($sformatf("row%0d_cs_errs", row_no), cs_errs, 0);
        chk($sformatf("row%0d_last_addr", row_no), last_addr, r.exp_last);
        chk($sformatf("row%0d_zero_addr", row_no), zero_addr, 1'b0);
        chk($sformatf("row%0d_idle_active", row_no), dma_active, 1'b0);
    endtask

    initial begin
        rows[0] = '{8'h02, 1'b1, -1, -1, 1, 513, 256, 16'h02FF};
        rows[1] = '{8'h02, 1'b0, -1, -1, 1, 514, 256, 16'h02FF};
        rows[2] = '{8'hFF, 1'b1, -1, -1, 1, 513, 256, 16'hFFFF};
        rows[3] = '{8'h03, 1'b0, 100, -1, 1, 514, 256, 16'h03FF};
        rows[4] = '{8'h05, 1'b1, -1, 50, 1, 0, 50, 16'h0531};
        rows[5] = '{8'h06, 1'b1, -1, -1, 1, 513, 256, 16'h06FF};
        rows[6] = '{8'h02, 1'b1, -1, -1, 3, 513, 256, 16'h02FF};

        rst = 1'b1; cpu_ce = 1'b0; cpu_addr_i = 16'h0; cpu_data_i = 8'h0; cpu_rw_i = 1'b1;
        writes = 0; cur_page = 8'h0; zero_addr = 1'b0;
        tick(1'b1);
        tick(1'b0);
        rst = 1'b0;
        ce_count = 0;

        chk("reset_cpu_halt", cpu_halt, 1'b0);
        chk("reset_dma_active", dma_active, 1'b0);
        chk("reset_bus_addr", bus_addr_o, 16'h0000);
        chk("reset_bus_rw", bus_rw_o, 1'b1);
        chk("reset_ppu_cs", ppu_cs, 1'b0);
        chk("reset_ppu_addr", ppu_addr, 3'd4);
        chk("reset_ppu_rw", ppu_rw, 1'b1);
        chk("reset_ppu_data", ppu_data, 8'h00);

        // A CPU read of the trigger address must not start a transfer.
        cpu_addr_i = 16'h4014; cpu_rw_i = 1'b1; cpu_data_i = 8'h02;
        cpu_cycle();
        cpu_addr_i = 16'h0000;
        chk("read_no_trigger", cpu_halt, 1'b0);

        for (int i = 0; i < 7; i++) do_transfer(rows[i], i);

        // Back-to-back: a trigger in the first cycle after halt drops is accepted.
        ce_period = 1;
        cpu_addr_i = 16'h4014; cpu_rw_i = 1'b0; cpu_data_i = 8'h09;
        cpu_cycle();
        cpu_addr_i = 16'h0000; cpu_rw_i = 1'b1;
        chk("retrigger_after_done", cpu_halt, 1'b1);
        chk("retrigger_page_addr", bus_addr_o, 16'h0900);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
